thread_scheduler: RTL and testbench

THREAD_SCHEDULER -- requirements
Module: thread_scheduler

---
 rtl/thread_scheduler.sv | 103 ++++++++++
 tb/tb_thread_scheduler.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/thread_scheduler.sv
// Two-thread round-robin fetch scheduler.
// Picks one eligible thread per cycle and registers its PC toward instruction memory.
// Taken-branch redirects are applied even while stalled, so a redirect is never dropped.
// A branch whose target equals its own address (a self-loop) halts that thread.
// The halt flag stays set until reset.
module thread_scheduler #(
  parameter logic [7:0] T0_START = 8'd0,
  parameter logic [7:0] T1_START = 8'd100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] thread_en,
  input  logic       stall,
  input  logic       br_valid,
  input  logic       br_tid,
  input  logic [7:0] br_pc,
  input  logic [7:0] br_target,
  output logic       fetch_valid,
  output logic [7:0] fetch_pc,
  output logic       fetch_tid,
  output logic [1:0] thread_done
);

  logic [1:0][7:0] pc_q, pc_d;
  logic            last_tid_q, last_tid_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic [7:0]      fetch_pc_q, fetch_pc_d;
  logic            fetch_tid_q, fetch_tid_d;
  logic [1:0]      done_q, done_d;

  logic [1:0] eligible;
  logic       sel_valid;
  logic       sel_tid;
  logic       br_hits_sel;

  // Round-robin selection plus next-state for PCs, fetch outputs and halt flags.
  always_comb begin
    pc_d          = pc_q;
    last_tid_d    = last_tid_q;
    fetch_valid_d = fetch_valid_q;
    fetch_pc_d    = fetch_pc_q;
    fetch_tid_d   = fetch_tid_q;
    done_d        = done_q;

    eligible  = thread_en & ~done_q;
    sel_valid = 1'b0;
    sel_tid   = last_tid_q;
    if (eligible[~last_tid_q]) begin
      sel_valid = 1'b1;
      sel_tid   = ~last_tid_q;
    end else if (eligible[last_tid_q]) begin
      sel_valid = 1'b1;
      sel_tid   = last_tid_q;
    end

    // A redirect aimed at the thread being fetched this cycle replaces its stale PC.
    br_hits_sel = br_valid && !stall && sel_valid && (br_tid == sel_tid);

    if (!stall) begin
      fetch_valid_d = sel_valid;
      if (sel_valid) begin
        fetch_tid_d     = sel_tid;
        last_tid_d      = sel_tid;
        fetch_pc_d      = br_hits_sel ? br_target : pc_q[sel_tid];
        pc_d[sel_tid]   = fetch_pc_d + 8'd2;
      end
    end

    if (br_valid && !br_hits_sel) begin
      pc_d[br_tid] = br_target;
    end

    if (br_valid && (br_target == br_pc)) begin
      done_d[br_tid] = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q[0]       <= T0_START;
      pc_q[1]       <= T1_START;
      last_tid_q    <= 1'b1;
      fetch_valid_q <= 1'b0;
      fetch_pc_q    <= 8'd0;
      fetch_tid_q   <= 1'b0;
      done_q        <= 2'b00;
    end else begin
      pc_q          <= pc_d;
      last_tid_q    <= last_tid_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_pc_q    <= fetch_pc_d;
      fetch_tid_q   <= fetch_tid_d;
      done_q        <= done_d;
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign fetch_pc    = fetch_pc_q;
  assign fetch_tid   = fetch_tid_q;
  assign thread_done = done_q;

endmodule

// File: tb/tb_thread_scheduler.sv
// Directed bench for thread_scheduler.
// Inputs are driven between negative edges.
// Registered outputs are sampled on the following negative edge.
module tb_thread_scheduler;

  logic       clk;
  logic       rst;
  logic [1:0] thread_en;
  logic       stall;
  logic       br_valid;
  logic       br_tid;
  logic [7:0] br_pc;
  logic [7:0] br_target;
  logic       fetch_valid;
  logic [7:0] fetch_pc;
  logic       fetch_tid;
  logic [1:0] thread_done;

  int n_checks;
  int n_fail;

  thread_scheduler #(
    .T0_START(8'd0),
    .T1_START(8'd100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .thread_en  (thread_en),
    .stall      (stall),
    .br_valid   (br_valid),
    .br_tid     (br_tid),
    .br_pc      (br_pc),
    .br_target  (br_target),
    .fetch_valid(fetch_valid),
    .fetch_pc   (fetch_pc),
    .fetch_tid  (fetch_tid),
    .thread_done(thread_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; thread_en = 2'b11; stall = 1'b0;
    br_valid = 1'b0; br_tid = 1'b0; br_pc = 8'd0; br_target = 8'd0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (fetch_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid got %b want 0", fetch_valid);
    end
    n_checks++;
    if (fetch_pc !== 8'd0) begin
      n_fail++; $display("FAIL reset_pc got %0d want 0", fetch_pc);
    end
    n_checks++;
    if (fetch_tid !== 1'b0) begin
      n_fail++; $display("FAIL reset_tid got %b want 0", fetch_tid);
    end
    n_checks++;
    if (thread_done !== 2'b00) begin
      n_fail++; $display("FAIL reset_done got %b want 00", thread_done);
    end
  endtask

  task automatic test_interleave();
    logic       exp_tid [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] exp_pc  [5] = '{8'd0, 8'd100, 8'd2, 8'd102, 8'd4};
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (fetch_valid !== 1'b1 || fetch_tid !== exp_tid[i] || fetch_pc !== exp_pc[i]) begin
        n_fail++;
        $display("FAIL interleave[%0d] got v=%b tid=%b pc=%0d want v=1 tid=%b pc=%0d",
                 i, fetch_valid, fetch_tid, fetch_pc, exp_tid[i], exp_pc[i]);
      end
    end
  endtask

  task automatic test_redirect();
    logic       et;
    logic [7:0] ep;
    // Run on until thread 1 fetches 118.
    for (int k = 0; k < 15; k++) begin
      et = (k % 2 == 0);
      ep = et ? 8'(104 + k) : 8'(6 + k - 1);
      @(negedge clk);
      n_checks++;
      if (fetch_tid !== et || fetch_pc !== ep) begin
        n_fail++;
        $display("FAIL run[%0d] got tid=%b pc=%0d want tid=%b pc=%0d", k, fetch_tid, fetch_pc, et, ep);
      end
    end
    // Branch at 118 resolves while thread 0 is being selected.
    br_valid = 1'b1; br_tid = 1'b1; br_pc = 8'd118; br_target = 8'd110;
    @(negedge clk);
    br_valid = 1'b0;
    n_checks++;
    if (fetch_tid !== 1'b0 || fetch_pc !== 8'd20) begin
      n_fail++; $display("FAIL redir_t0 got tid=%b pc=%0d want tid=0 pc=20", fetch_tid, fetch_pc);
    end
    @(negedge clk);
    n_checks++;
    if (fetch_tid !== 1'b1 || fetch_pc !== 8'd110) begin
      n_fail++; $display("FAIL redir_target got tid=%b pc=%0d want tid=1 pc=110", fetch_tid, fetch_pc);
    end
    @(negedge clk);
    n_checks++;
    if (fetch_tid !== 1'b0 || fetch_pc !== 8'd22) begin
      n_fail++; $display("FAIL redir_t0b got tid=%b pc=%0d want tid=0 pc=22", fetch_tid, fetch_pc);
    end
    @(negedge clk);
    n_checks++;
    if (fetch_tid !== 1'b1 || fetch_pc !== 8'd112) begin
      n_fail++; $display("FAIL redir_next got tid=%b pc=%0d want tid=1 pc=112", fetch_tid, fetch_pc);
    end
  endtask

  task automatic test_halt();
    // Thread 0 is selected this cycle, so its self-loop redirect becomes the fetch address.
    br_valid = 1'b1; br_tid = 1'b0; br_pc = 8'd12; br_target = 8'd12;
    @(negedge clk);
    br_valid = 1'b0;
    n_checks++;
    if (fetch_tid !== 1'b0 || fetch_pc !== 8'd12 || thread_done !== 2'b01) begin
      n_fail++;
      $display("FAIL halt0 got tid=%b pc=%0d done=%b want tid=0 pc=12 done=01",
               fetch_tid, fetch_pc, thread_done);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (fetch_valid !== 1'b1 || fetch_tid !== 1'b1 || fetch_pc !== 8'(114 + 2 * i)
          || thread_done !== 2'b01) begin
        n_fail++;
        $display("FAIL halt_only_t1[%0d] got v=%b tid=%b pc=%0d done=%b want v=1 tid=1 pc=%0d done=01",
                 i, fetch_valid, fetch_tid, fetch_pc, thread_done, 114 + 2 * i);
      end
    end
    // Halt thread 1 too.
    br_valid = 1'b1; br_tid = 1'b1; br_pc = 8'd120; br_target = 8'd120;
    @(negedge clk);
    br_valid = 1'b0;
    n_checks++;
    if (fetch_tid !== 1'b1 || fetch_pc !== 8'd120 || thread_done !== 2'b11) begin
      n_fail++;
      $display("FAIL halt1 got tid=%b pc=%0d done=%b want tid=1 pc=120 done=11",
               fetch_tid, fetch_pc, thread_done);
    end
    @(negedge clk);
    n_checks++;
    if (fetch_valid !== 1'b0 || fetch_pc !== 8'd120 || fetch_tid !== 1'b1
        || thread_done !== 2'b11) begin
      n_fail++;
      $display("FAIL halt_idle got v=%b tid=%b pc=%0d done=%b want v=0 tid=1 pc=120 done=11",
               fetch_valid, fetch_tid, fetch_pc, thread_done);
    end
  endtask

  task automatic test_reset_mid_run();
    rst = 1'b1; stall = 1'b1; thread_en = 2'b11;
    br_valid = 1'b1; br_tid = 1'b0; br_pc = 8'd77; br_target = 8'd77;
    @(negedge clk);
    n_checks++;
    if (fetch_valid !== 1'b0 || fetch_pc !== 8'd0 || fetch_tid !== 1'b0
        || thread_done !== 2'b00) begin
      n_fail++;
      $display("FAIL midreset got v=%b tid=%b pc=%0d done=%b want v=0 tid=0 pc=0 done=00",
               fetch_valid, fetch_tid, fetch_pc, thread_done);
    end
    rst = 1'b0; stall = 1'b0; br_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (fetch_valid !== 1'b1 || fetch_tid !== 1'b0 || fetch_pc !== 8'd0) begin
      n_fail++;
      $display("FAIL midreset_first got v=%b tid=%b pc=%0d want v=1 tid=0 pc=0",
               fetch_valid, fetch_tid, fetch_pc);
    end
    @(negedge clk);
    n_checks++;
    if (fetch_tid !== 1'b1 || fetch_pc !== 8'd100) begin
      n_fail++; $display("FAIL midreset_second got tid=%b pc=%0d want tid=1 pc=100", fetch_tid, fetch_pc);
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    n_checks++;
    if (fetch_tid !== 1'b0 || fetch_pc !== 8'd2) begin
      n_fail++; $display("FAIL prestall got tid=%b pc=%0d want tid=0 pc=2", fetch_tid, fetch_pc);
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (fetch_valid !== 1'b1 || fetch_tid !== 1'b0 || fetch_pc !== 8'd2) begin
        n_fail++;
        $display("FAIL stall_hold[%0d] got v=%b tid=%b pc=%0d want v=1 tid=0 pc=2",
                 i, fetch_valid, fetch_tid, fetch_pc);
      end
    end
    stall = 1'b0;
    @(negedge clk);
    n_checks++;
    if (fetch_tid !== 1'b1 || fetch_pc !== 8'd102) begin
      n_fail++; $display("FAIL stall_resume got tid=%b pc=%0d want tid=1 pc=102", fetch_tid, fetch_pc);
    end
    @(negedge clk);
    n_checks++;
    if (fetch_tid !== 1'b0 || fetch_pc !== 8'd4) begin
      n_fail++; $display("FAIL stall_resume2 got tid=%b pc=%0d want tid=0 pc=4", fetch_tid, fetch_pc);
    end
  endtask

  task automatic test_idle_wrap();
    logic [7:0] exp_pc [3] = '{8'd254, 8'd0, 8'd2};
    thread_en = 2'b00;
    br_valid = 1'b1; br_tid = 1'b0; br_pc = 8'd0; br_target = 8'd254;
    @(negedge clk);
    br_valid = 1'b0;
    n_checks++;
    if (fetch_valid !== 1'b0 || fetch_pc !== 8'd4 || fetch_tid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle got v=%b tid=%b pc=%0d want v=0 tid=0 pc=4", fetch_valid, fetch_tid, fetch_pc);
    end
    @(negedge clk);
    n_checks++;
    if (fetch_valid !== 1'b0) begin
      n_fail++; $display("FAIL idle2 got v=%b want v=0", fetch_valid);
    end
    thread_en = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (fetch_valid !== 1'b1 || fetch_tid !== 1'b0 || fetch_pc !== exp_pc[i]) begin
        n_fail++;
        $display("FAIL wrap[%0d] got v=%b tid=%b pc=%0d want v=1 tid=0 pc=%0d",
                 i, fetch_valid, fetch_tid, fetch_pc, exp_pc[i]);
      end
    end
    // A redirect for thread 1 during a stall must not be lost.
    thread_en = 2'b10; stall = 1'b1;
    br_valid = 1'b1; br_tid = 1'b1; br_pc = 8'd5; br_target = 8'd40;
    @(negedge clk);
    br_valid = 1'b0; stall = 1'b0;
    n_checks++;
    if (fetch_valid !== 1'b1 || fetch_tid !== 1'b0 || fetch_pc !== 8'd2) begin
      n_fail++;
      $display("FAIL stall_br_hold got v=%b tid=%b pc=%0d want v=1 tid=0 pc=2",
               fetch_valid, fetch_tid, fetch_pc);
    end
    @(negedge clk);
    n_checks++;
    if (fetch_valid !== 1'b1 || fetch_tid !== 1'b1 || fetch_pc !== 8'd40
        || thread_done !== 2'b00) begin
      n_fail++;
      $display("FAIL stall_br_apply got v=%b tid=%b pc=%0d done=%b want v=1 tid=1 pc=40 done=00",
               fetch_valid, fetch_tid, fetch_pc, thread_done);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_interleave();
    test_redirect();
    test_halt();
    test_reset_mid_run();
    test_stall();
    test_idle_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
